// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: cache line-1 request/response, execute redirect,
// and the instruction handshake toward decode.
interface fetch_if;
   logic [63:0] req_addr;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] resp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_ready;

   modport master (
      output req_addr, req_valid, resp_ready, instr_valid, instr, instr_pc,
      input  req_ready, resp_data, resp_valid, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  req_addr, req_valid, resp_ready, instr_valid, instr, instr_pc,
      output req_ready, resp_data, resp_valid, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding 8-byte read at a time, each returned word
// split into two 32-bit instructions for decode, with redirect/discard handling.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input logic     clk,
   input logic     reset,
   fetch_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] word_q, word_d;
   logic        discard_q, discard_d;
   logic [63:0] redirect_aligned;

   assign redirect_aligned = bus.redirect_pc & ~64'd3;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      word_d          = word_q;
      discard_d       = discard_q;
      bus.req_valid   = 1'b0;
      bus.req_addr    = 64'd0;
      bus.resp_ready  = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'd0;
      bus.instr_pc    = 64'd0;

      case (state_q)
         S_REQ: begin
            bus.req_valid = !reset;
            bus.req_addr  = reset ? 64'd0 : {pc_q[63:3], 3'b000};
            if (bus.redirect_valid) pc_d = redirect_aligned;
            // A request accepted alongside a redirect fetches the stale line.
            if (bus.req_ready) begin
               state_d   = S_WAIT;
               discard_d = bus.redirect_valid;
            end
         end
         S_WAIT: begin
            bus.resp_ready = !reset;
            if (bus.redirect_valid) pc_d = redirect_aligned;
            if (bus.resp_valid) begin
               if (discard_q || bus.redirect_valid) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  word_d  = bus.resp_data;
                  state_d = S_DRAIN;
               end
            end else if (bus.redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!reset) begin
               bus.instr_valid = 1'b1;
               bus.instr_pc    = pc_q;
               bus.instr       = pc_q[2] ? word_q[63:32] : word_q[31:0];
            end
            if (bus.redirect_valid) begin
               pc_d    = redirect_aligned;
               state_d = S_REQ;
            end else if (bus.instr_ready) begin
               pc_d = pc_q + 64'd4;
               if (pc_q[2]) state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: plays cache and decode, predicts the fetched stream
// from PC/redirect rules and a memory image, directed then random traffic.
module tb_fetch_unit;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   fetch_if bus ();

   fetch_unit #(.RESET_PC(64'h1000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: architectural fetch PC, requests in flight,
   // whether an in-flight request became stale, and whether a word is held.
   logic [63:0] m_pc;
   logic [63:0] outq[$];
   bit          stale;
   bit          have;
   logic [63:0] ovr[logic [63:0]];

   function automatic logic [31:0] f(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [63:0] memword(input logic [63:0] a);
      if (ovr.exists(a)) return ovr[a];
      return {f(a + 64'd4), f(a)};
   endfunction

   function automatic logic [31:0] exp_instr(input logic [63:0] pc);
      logic [63:0] w;
      w = memword({pc[63:3], 3'b000});
      return pc[2] ? w[63:32] : w[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      m_pc  = 64'h1000;
      outq.delete();
      stale = 1'b0;
      have  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, {63'd0, bus.req_valid}, 64'd0);
      chk({tag, "_resp_ready"}, {63'd0, bus.resp_ready}, 64'd0);
      chk({tag, "_instr_valid"}, {63'd0, bus.instr_valid}, 64'd0);
      chk({tag, "_instr"}, {32'd0, bus.instr}, 64'd0);
      chk({tag, "_instr_pc"}, bus.instr_pc, 64'd0);
      chk({tag, "_req_addr"}, bus.req_addr, 64'd0);
   endtask

   // One clock: drive inputs at negedge, check outputs against the model,
   // advance the model by this edge's handshakes, return #1 after posedge.
   task automatic step(input bit rr, input bit rv, input bit ir, input bit rd,
                       input logic [63:0] rpc);
      bit req_hs, resp_hs, ins_hs, req_exp;
      @(negedge clk);
      bus.req_ready      = rr;
      bus.resp_valid     = rv && (outq.size() != 0);
      bus.resp_data      = (outq.size() != 0) ? memword(outq[0]) : 64'd0;
      bus.instr_ready    = ir;
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;

      req_exp = (outq.size() == 0) && !have;
      chk("req_valid", {63'd0, bus.req_valid}, {63'd0, req_exp});
      chk("resp_ready", {63'd0, bus.resp_ready}, {63'd0, outq.size() != 0});
      chk("instr_valid", {63'd0, bus.instr_valid}, {63'd0, have});
      if (req_exp) chk("req_addr", bus.req_addr, {m_pc[63:3], 3'b000});
      chk("instr_pc", bus.instr_pc, have ? m_pc : 64'd0);
      chk("instr", {32'd0, bus.instr}, {32'd0, have ? exp_instr(m_pc) : 32'd0});

      req_hs  = bus.req_valid && bus.req_ready;
      resp_hs = bus.resp_valid && bus.resp_ready;
      ins_hs  = bus.instr_valid && bus.instr_ready;
      if (resp_hs) begin
         void'(outq.pop_front());
         if (!stale && !rd) have = 1'b1;
         stale = 1'b0;
      end
      if (req_hs) begin
         outq.push_back({m_pc[63:3], 3'b000});
         stale = rd;
      end else if (rd && outq.size() != 0) begin
         stale = 1'b1;
      end
      if (rd) begin
         have = 1'b0;
         m_pc = rpc & ~64'd3;
      end else if (ins_hs) begin
         if (m_pc[2]) have = 1'b0;
         m_pc = m_pc + 64'd4;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rand_pc();
      case ($urandom_range(0, 3))
         0:       return {$urandom, $urandom};
         1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         default: return 64'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      model_init();
      ovr[64'h1000] = 64'hBBBBBBBB_AAAAAAAA;
      ovr[64'h2000] = 64'h22222222_11111111;
      ovr[64'h2008] = 64'h0000_0000_0000_DEAD;
      bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = 64'd0;
      bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("first_req_valid", {63'd0, bus.req_valid}, 64'd1);
      chk("first_req_addr", bus.req_addr, 64'h1000);

      // Straight-line word: two instructions then the next line.
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("w0_instr", {32'd0, bus.instr}, 64'hAAAAAAAA);
      chk("w0_pc", bus.instr_pc, 64'h1000);
      step(0, 0, 1, 0, 0);
      chk("w1_instr", {32'd0, bus.instr}, 64'hBBBBBBBB);
      chk("w1_pc", bus.instr_pc, 64'h1004);
      step(0, 0, 1, 0, 0);
      chk("next_req_addr", bus.req_addr, 64'h1008);

      // Redirect into the upper half of a line.
      step(0, 0, 0, 1, 64'h2004);
      chk("redir_req_addr", bus.req_addr, 64'h2000);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("hi_instr", {32'd0, bus.instr}, 64'h22222222);
      chk("hi_pc", bus.instr_pc, 64'h2004);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0);
         chk("stall_valid", {63'd0, bus.instr_valid}, 64'd1);
         chk("stall_instr", {32'd0, bus.instr}, 64'h22222222);
         chk("stall_pc", bus.instr_pc, 64'h2004);
         chk("stall_noreq", {63'd0, bus.req_valid}, 64'd0);
      end
      step(0, 0, 1, 0, 0);
      chk("after_hi_req", bus.req_addr, 64'h2008);

      // Redirect while waiting: the response is dropped.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 64'h3000);
      step(0, 1, 0, 0, 0);
      chk("drop_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
      chk("drop_req_valid", {63'd0, bus.req_valid}, 64'd1);
      chk("drop_req_addr", bus.req_addr, 64'h3000);

      // PC wrap at the top of the address space.
      step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_req_addr", bus.req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("wrap_pc_top", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 0, 1, 0, 0);
      chk("wrap_req_zero", bus.req_addr, 64'h0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("wrap_pc_zero", bus.instr_pc, 64'h0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);

      // Request held unaccepted, then retargeted.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0);
         chk("hold_req_valid", {63'd0, bus.req_valid}, 64'd1);
         chk("hold_req_addr", bus.req_addr, 64'h8);
      end
      step(0, 0, 0, 1, 64'h4000);
      chk("retarget_valid", {63'd0, bus.req_valid}, 64'd1);
      chk("retarget_addr", bus.req_addr, 64'h4000);

      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rand_pc());
      end

      // Reset in the middle of traffic.
      @(negedge clk);
      bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
      bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      model_init();
      @(posedge clk);
      #1;
      chk("midrst_req_valid", {63'd0, bus.req_valid}, 64'd1);
      chk("midrst_req_addr", bus.req_addr, 64'h1000);
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("midrst_instr", {32'd0, bus.instr}, 64'hAAAAAAAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
